// File: rtl/fetch_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the fetch-stage sequencer.
//            - fetch_state_t : sequencer state encoding
//            - PC_INCR       : byte step between sequential fetches
//            - INSTR_W       : default instruction width
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int PC_INCR = 4;
    localparam int INSTR_W = 32;

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : fetch_ctrl_if
// Purpose  : Bundles the instruction-memory request/grant/response port and
//            the valid/ready delivery port toward decode.
//            master : fetch side (drives imem_req/imem_addr, if_valid/pc/instr)
//            slave  : memory + decode side (drives gnt/rvalid/rdata, if_ready)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int N  = 64,
    parameter int IW = INSTR_W
) ();

    logic          imem_req;
    logic [N-1:0]  imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;

    logic          if_valid;
    logic          if_ready;
    logic [N-1:0]  if_pc;
    logic [IW-1:0] if_instr;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_gnt, imem_rvalid, imem_rdata, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_gnt, imem_rvalid, imem_rdata, if_ready
    );

endinterface

`default_nettype wire

// File: rtl/fetch_ctrl_out_reg.sv
//------------------------------------------------------------------------------
// Module   : fetch_out_reg
// Purpose  : One-entry valid/ready holding register feeding decode.
//            load  : capture load_pc/load_instr and raise valid (wins over clear)
//            clear : drop valid, payload keeps its last value
//            neither: hold everything
// Ports    : clk, reset (async, active-high), load, clear, load_pc,
//            load_instr, valid, pc, instr
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_out_reg #(
    parameter int N  = 64,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic [N-1:0]  load_pc,
    input  logic [IW-1:0] load_instr,
    output logic          valid,
    output logic [N-1:0]  pc,
    output logic [IW-1:0] instr
);

    logic          r_valid;
    logic [N-1:0]  r_pc;
    logic [IW-1:0] r_instr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            if (load) begin
                r_valid <= 1'b1;
                r_pc    <= load_pc;
                r_instr <= load_instr;
            end else if (clear) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid = r_valid;
    assign pc    = r_pc;
    assign instr = r_instr;

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : fetch_ctrl
// Purpose  : Fetch-stage sequencer. Owns the PC, issues one instruction-memory
//            transaction at a time and hands results to decode through a
//            one-entry valid/ready register. Redirects flush the output and
//            retarget the PC; an in-flight response is drained and dropped.
// Ports    : clk, reset (async, active-high)
//            redirect_valid, redirect_addr : branch/flush redirect
//            bus (fetch_ctrl_if.master)    : imem req/gnt/rvalid + decode port
//            perf_fetched, perf_stall      : only with FETCH_PERF_CNT_EN
// Config   : `define FETCH_PERF_CNT_EN adds saturating 32-bit delivery and
//            stall counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int           N        = 64,
    parameter int           IW       = INSTR_W,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_addr,
    fetch_ctrl_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall
`endif
);

    localparam logic [N-1:0] c_pc_incr = N'(PC_INCR);

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [N-1:0]  r_pc;
    logic          w_req;
    logic          w_load;
    logic          w_clear;
    logic          w_if_valid;
    logic [N-1:0]  w_if_pc;
    logic [IW-1:0] w_if_instr;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. A redirect in REQ needs no explicit term: it masks
    // the request, so the state simply stays in REQ at the new pc.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  w_state_nxt = REQ;
            REQ:   if (w_req && bus.imem_gnt) w_state_nxt = WAIT;
            // A response coinciding with a redirect completes the
            // transaction, so there is nothing left to drain.
            WAIT:  if (bus.imem_rvalid)       w_state_nxt = REQ;
                   else if (redirect_valid)   w_state_nxt = DRAIN;
            // The stale response ends the drain; any redirect meanwhile only
            // retargets the pc.
            DRAIN: if (bus.imem_rvalid)       w_state_nxt = REQ;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_req  = 1'b0;
        w_load = 1'b0;
        case (r_state)
            // Only request when the output slot is free or being freed, so
            // a returning instruction always has somewhere to land.
            REQ:  w_req  = (!w_if_valid || bus.if_ready) && !redirect_valid;
            WAIT: w_load = bus.imem_rvalid && !redirect_valid;
            default: ;
        endcase
    end

    assign w_clear       = redirect_valid || (w_if_valid && bus.if_ready);
    assign bus.imem_req  = w_req;
    assign bus.imem_addr = w_req ? r_pc : '0;

    // Program counter; wraps naturally at 2^N.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_addr;
        end else if (w_load) begin
            r_pc <= r_pc + c_pc_incr;
        end
    end

    fetch_out_reg #(
        .N  (N),
        .IW (IW)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .clear      (w_clear),
        .load_pc    (r_pc),
        .load_instr (bus.imem_rdata),
        .valid      (w_if_valid),
        .pc         (w_if_pc),
        .instr      (w_if_instr)
    );

    assign bus.if_valid = w_if_valid;
    assign bus.if_pc    = w_if_pc;
    assign bus.if_instr = w_if_instr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_if_valid && bus.if_ready && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_if_valid && !bus.if_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_fetch_ctrl
// Purpose  : Self-checking bench for fetch_ctrl (N=8, RESET_PC=0xFC so the
//            PC wrap is reached). A transaction-level model tracks the
//            expected next fetch address, the outstanding/flushed request and
//            the decode slot; a small memory responder answers grants after
//            a random latency. FETCH_PERF_CNT_EN also checks the counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int           N        = 8;
    localparam int           IW       = 32;
    localparam logic [N-1:0] RESET_PC = 8'hFC;

    logic         clk = 1'b0;
    logic         reset;
    logic         redirect_valid;
    logic [N-1:0] redirect_addr;

    fetch_ctrl_if #(.N(N), .IW(IW)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_ctrl #(
        .N        (N),
        .IW       (IW),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .bus            (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory contents: a fixed scramble of the address.
    function automatic logic [IW-1:0] instr_of(input logic [N-1:0] a);
        logic [31:0] v;
        v = (32'(a) * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
        return v;
    endfunction

    // Reference model
    logic [N-1:0]  m_pc;
    logic          m_out;
    logic          m_flushed;
    logic [N-1:0]  m_out_addr;
    logic          m_held;
    logic [N-1:0]  m_held_pc;
    logic [IW-1:0] m_held_instr;
    logic [31:0]   m_fetched;
    logic [31:0]   m_stall;

    // Memory responder
    logic          mem_busy;
    int            mem_cnt;
    logic [N-1:0]  mem_addr;

    // Stimulus knobs
    int p_ready, p_redir, p_gnt, lat_max;
    int cyc, last_req_cyc;
    logic chk_gap;
    logic [N-1:0] req_log[$];

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_out     = 1'b0;
        m_flushed = 1'b0;
        m_held    = 1'b0;
        m_fetched = '0;
        m_stall   = '0;
        mem_busy  = 1'b0;
        mem_cnt   = 0;
        last_req_cyc = -1;
    endtask

    task automatic check_perf(input string tag);
`ifdef FETCH_PERF_CNT_EN
        check_eq({tag, "_perf_fetched"}, perf_fetched, m_fetched);
        check_eq({tag, "_perf_stall"}, perf_stall, m_stall);
`endif
    endtask

    // Reset around an in-flight transaction; optional stale rvalid is held
    // through reset and into the first cycle after release.
    task automatic do_reset(input logic stale);
        @(posedge clk); #1;
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        bus.if_ready    = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = stale;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check_eq("rst_imem_req", bus.imem_req, 0);
        check_eq("rst_imem_addr", bus.imem_addr, 0);
        check_eq("rst_if_valid", bus.if_valid, 0);
        check_eq("rst_if_pc", bus.if_pc, 0);
        check_eq("rst_if_instr", bus.if_instr, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        #2;
        check_eq("idle_imem_req", bus.imem_req, 0);
        check_eq("idle_if_valid", bus.if_valid, 0);
        model_reset();
        check_perf("idle");
    endtask

    task automatic step();
        logic exp_req;
        logic rv;
        @(posedge clk); #1;
        cyc++;
        bus.if_ready    = ($urandom_range(99) < p_ready);
        redirect_valid  = ($urandom_range(99) < p_redir);
        redirect_addr   = N'($urandom);
        bus.imem_gnt    = ($urandom_range(99) < p_gnt);
        rv              = mem_busy && (mem_cnt == 0);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? instr_of(mem_addr) : IW'($urandom);
        #3;

        check_eq("if_valid", bus.if_valid, m_held);
        if (m_held) begin
            check_eq("if_pc", bus.if_pc, m_held_pc);
            check_eq("if_instr", bus.if_instr, m_held_instr);
        end
        exp_req = !m_out && (!m_held || bus.if_ready) && !redirect_valid;
        check_eq("imem_req", bus.imem_req, exp_req);
        if (exp_req) begin
            check_eq("imem_addr", bus.imem_addr, m_pc);
            if (chk_gap) begin
                req_log.push_back(bus.imem_addr);
                if (last_req_cyc >= 0) check_eq("req_gap", cyc - last_req_cyc, 2);
                last_req_cyc = cyc;
            end
        end
        check_perf("cyc");

        // Memory responder follows what the DUT actually did.
        if (rv) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (bus.imem_req && bus.imem_gnt) begin
            mem_busy = 1'b1;
            mem_cnt  = int'($urandom_range(lat_max));
            mem_addr = bus.imem_addr;
        end

        // Model commit for this clock edge.
        if (m_held && bus.if_ready && m_fetched != 32'hFFFF_FFFF) m_fetched++;
        if (m_held && !bus.if_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (redirect_valid) begin
            if (m_out && rv) m_out = 1'b0;
            else if (m_out)  m_flushed = 1'b1;
            m_pc   = redirect_addr;
            m_held = 1'b0;
        end else begin
            if (m_held && bus.if_ready) m_held = 1'b0;
            if (m_out && rv) begin
                m_out = 1'b0;
                if (!m_flushed) begin
                    m_held       = 1'b1;
                    m_held_pc    = m_out_addr;
                    m_held_instr = instr_of(m_out_addr);
                    m_pc         = m_out_addr + N'(PC_INCR);
                end
            end else if (exp_req && bus.imem_gnt) begin
                m_out      = 1'b1;
                m_flushed  = 1'b0;
                m_out_addr = m_pc;
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_addr   = '0;
        bus.if_ready    = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        cyc = 0;
        model_reset();

        // Full-rate streaming across the PC wrap.
        p_ready = 100; p_redir = 0; p_gnt = 100; lat_max = 0; chk_gap = 1'b1;
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) step();
        chk_gap = 1'b0;
        if (req_log.size() >= 3) begin
            check_eq("wrap_addr0", req_log[0], 8'hFC);
            check_eq("wrap_addr1", req_log[1], 8'h00);
            check_eq("wrap_addr2", req_log[2], 8'h04);
        end else begin
            check_eq("wrap_req_count", req_log.size(), 3);
        end

        // Randomized traffic with stalls, redirects and occasional resets.
        p_ready = 65; p_redir = 8; p_gnt = 60; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            step();
            if ($urandom_range(299) == 0) do_reset(1'(($urandom_range(1))));
        end

        // Reset while a transaction is in flight, with stale responses.
        p_redir = 0; p_gnt = 100; p_ready = 100; lat_max = 3;
        for (int i = 0; i < 3; i++) step();
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
